// File: rtl/eth_tx_fcs_insert.sv
// Appends CRC-32 FCS (and optional zero pad) to a byte-stream frame; one registered output stage.
// Input byte accepted at edge N is on m_data in cycle N+1; s_ready drops while the output is stalled or in pad/FCS.
module eth_tx_fcs_insert #(
  parameter bit          PAD_EN  = 1'b1,
  parameter int unsigned MIN_LEN = 60
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic       frame_done
);

  typedef enum logic [1:0] {ST_DATA, ST_PAD, ST_FCS} state_t;

  localparam logic [8:0] MIN9 = 9'(MIN_LEN);
  localparam logic [7:0] MIN8 = 8'(MIN_LEN);

  state_t      state, state_nxt;
  logic [31:0] crc;
  logic [31:0] crc_result;
  logic [7:0]  cnt;
  logic [7:0]  cnt_inc;
  logic [8:0]  cnt_p1;
  logic [1:0]  idx;
  logic [7:0]  fcs_byte;
  logic        out_free;
  logic        accept;

  // Reflected CRC-32 (poly 0x04C11DB7), one byte per call.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  assign out_free   = !m_valid || m_ready;
  assign accept     = s_valid && s_ready;
  assign cnt_p1     = {1'b0, cnt} + 9'd1;
  assign cnt_inc    = (cnt >= MIN8) ? cnt : cnt + 8'd1;
  assign crc_result = ~crc;

  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_DATA;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_DATA: if (accept && s_last)
                 state_nxt = (PAD_EN && (cnt_p1 < MIN9)) ? ST_PAD : ST_FCS;
      ST_PAD:  if (out_free && (cnt_p1 == MIN9)) state_nxt = ST_FCS;
      ST_FCS:  if (out_free && (idx == 2'd3)) state_nxt = ST_DATA;
      default: state_nxt = ST_DATA;
    endcase
  end

  always_comb begin
    s_ready    = rstn && (state == ST_DATA) && out_free;
    frame_done = m_valid && m_ready && m_last;
    case (idx)
      2'd0:    fcs_byte = crc_result[7:0];
      2'd1:    fcs_byte = crc_result[15:8];
      2'd2:    fcs_byte = crc_result[23:16];
      default: fcs_byte = crc_result[31:24];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      m_data  <= 8'h00;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      crc     <= 32'hFFFF_FFFF;
      cnt     <= 8'd0;
      idx     <= 2'd0;
    end else begin
      case (state)
        ST_DATA: begin
          if (accept) begin
            m_data  <= s_data;
            m_valid <= 1'b1;
            m_last  <= 1'b0;
            crc     <= crc_byte(crc, s_data);
            cnt     <= cnt_inc;
          end else if (out_free) begin
            m_valid <= 1'b0;
          end
        end
        ST_PAD: begin
          if (out_free) begin
            m_data  <= 8'h00;
            m_valid <= 1'b1;
            m_last  <= 1'b0;
            crc     <= crc_byte(crc, 8'h00);
            cnt     <= cnt_inc;
          end
        end
        ST_FCS: begin
          // crc stays frozen until the last FCS byte so all four bytes share one value
          if (out_free) begin
            m_data  <= fcs_byte;
            m_valid <= 1'b1;
            m_last  <= (idx == 2'd3);
            idx     <= idx + 2'd1;
            if (idx == 2'd3) begin
              crc <= 32'hFFFF_FFFF;
              cnt <= 8'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_fcs_insert.sv
// Scoreboard bench: dut0 without padding, dut1 padding to 60 bytes; shared clock, reset, data and m_ready.
module tb_eth_tx_fcs_insert;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_valid0, s_valid1;
  logic       m_ready;
  logic       s_ready0, m_valid0, m_last0, frame_done0;
  logic       s_ready1, m_valid1, m_last1, frame_done1;
  logic [7:0] m_data0, m_data1;

  int total = 0;
  int bad   = 0;
  int mode  = 0;
  int ph    = 0;
  int cyc   = 0;
  int first_cyc = 0;
  int last_cyc  = 0;
  bit arm  = 0;
  bit ign1 = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic       pv_stall[2];
  logic [8:0] pv_out[2];
  bit         tail[2];
  logic [7:0] f9[$], f60[$], f61[$], f70[$];

  always #5 clk = ~clk;

  eth_tx_fcs_insert #(.PAD_EN(1'b0), .MIN_LEN(60)) dut0 (
    .clk(clk), .rstn(rstn), .s_data(s_data), .s_valid(s_valid0), .s_last(s_last),
    .s_ready(s_ready0), .m_data(m_data0), .m_valid(m_valid0), .m_last(m_last0),
    .m_ready(m_ready), .frame_done(frame_done0));

  eth_tx_fcs_insert #(.PAD_EN(1'b1), .MIN_LEN(60)) dut1 (
    .clk(clk), .rstn(rstn), .s_data(s_data), .s_valid(s_valid1), .s_last(s_last),
    .s_ready(s_ready1), .m_data(m_data1), .m_valid(m_valid1), .m_last(m_last1),
    .m_ready(m_ready), .frame_done(frame_done1));

  // Bit-serial reference CRC-32, LSB of each byte first.
  function automatic logic [31:0] crc_ref(input logic [7:0] b[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    foreach (b[i])
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ b[i][j];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    return ~c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int sel, input logic [8:0] v);
    if (sel == 0) q0.push_back(v);
    else          q1.push_back(v);
  endtask

  task automatic push_known0();
    foreach (f9[i]) q0.push_back({1'b0, f9[i]});
    q0.push_back(9'h026);
    q0.push_back(9'h039);
    q0.push_back(9'h0F4);
    q0.push_back(9'h1CB);
  endtask

  task automatic push_frame(input int sel, input logic [7:0] fr[$]);
    logic [7:0]  all[$];
    logic [31:0] c;
    all = fr;
    if (sel == 1) while (all.size() < 60) all.push_back(8'h00);
    c = crc_ref(all);
    foreach (all[i]) push(sel, {1'b0, all[i]});
    for (int i = 0; i < 4; i++) push(sel, {(i == 3) ? 1'b1 : 1'b0, c[8*i +: 8]});
  endtask

  task automatic drive_byte(input int sel, input logic [7:0] d, input logic last);
    int   n;
    logic got;
    n = 0;
    got = 1'b0;
    s_data = d;
    s_last = last;
    if (sel == 0) s_valid0 = 1'b1; else s_valid1 = 1'b1;
    while (!got && n < 2000) begin
      @(negedge clk);
      got = (sel == 0) ? s_ready0 : s_ready1;
      @(posedge clk); #1;
      n++;
    end
    s_valid0 = 1'b0;
    s_valid1 = 1'b0;
    s_last   = 1'b0;
    chk("accept", {31'd0, got}, 32'd1);
  endtask

  task automatic send(input int sel, input logic [7:0] fr[$], input int gap_max);
    foreach (fr[i]) begin
      repeat ($urandom_range(gap_max, 0)) begin @(posedge clk); #1; end
      drive_byte(sel, fr[i], (i == fr.size() - 1));
    end
  endtask

  task automatic wait_drain(input int sel);
    int n;
    n = 0;
    while (((sel == 0) ? q0.size() : q1.size()) != 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", (sel == 0) ? q0.size() : q1.size(), 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic mon(input int k, input logic sr, input logic [7:0] md, input logic mv,
                     input logic ml, input logic fd, input logic sv);
    logic [8:0] e;
    if (rstn && !(k == 1 && ign1)) begin
      if (pv_stall[k]) begin
        total++;
        assert ({mv, ml, md} === {1'b1, pv_out[k]}) else begin
          bad++;
          $error("FAIL hold%0d got=%03h want=%03h", k, {mv, ml, md}, {1'b1, pv_out[k]});
        end
      end
      if (mv && !m_ready) begin
        total++;
        assert (sr === 1'b0) else begin bad++; $error("FAIL stall_rdy%0d got=%b want=0", k, sr); end
      end
      if (mv && ml) tail[k] = 1'b0;
      if (tail[k]) begin
        total++;
        assert (sr === 1'b0) else begin bad++; $error("FAIL tail_rdy%0d got=%b want=0", k, sr); end
      end
      if (sv && sr && s_last) tail[k] = 1'b1;
      if (mv && m_ready) begin
        if (k == 0) begin
          if (arm) begin first_cyc = cyc; arm = 0; end
          last_cyc = cyc;
        end
        total++;
        assert (((k == 0) ? q0.size() : q1.size()) != 0) else begin
          bad++;
          $error("FAIL extra_beat%0d got=%02h want=none", k, md);
        end
        if (((k == 0) ? q0.size() : q1.size()) != 0) begin
          e = (k == 0) ? q0.pop_front() : q1.pop_front();
          total++;
          assert ({ml, md} === e) else begin bad++; $error("FAIL beat%0d got=%03h want=%03h", k, {ml, md}, e); end
          total++;
          assert (fd === e[8]) else begin bad++; $error("FAIL done%0d got=%b want=%b", k, fd, e[8]); end
        end
      end else begin
        total++;
        assert (fd === 1'b0) else begin bad++; $error("FAIL idle_done%0d got=%b want=0", k, fd); end
      end
      pv_stall[k] = mv && !m_ready;
      pv_out[k]   = {ml, md};
    end else begin
      pv_stall[k] = 1'b0;
      tail[k]     = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    mon(0, s_ready0, m_data0, m_valid0, m_last0, frame_done0, s_valid0);
    mon(1, s_ready1, m_data1, m_valid1, m_last1, frame_done1, s_valid1);
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      ph++;
      m_ready = (mode == 0) ? 1'b1 : ((ph % 4 == 0) || (ph % 4 == 3));
    end
  end

  initial begin
    rstn = 1'b0; s_data = 8'h00; s_last = 1'b0; s_valid0 = 1'b0; s_valid1 = 1'b0;
    pv_stall[0] = 1'b0; pv_stall[1] = 1'b0; tail[0] = 1'b0; tail[1] = 1'b0;
    pv_out[0] = 9'h0; pv_out[1] = 9'h0;
    for (int i = 0; i < 9; i++) f9.push_back(8'h31 + 8'(i));
    for (int i = 0; i < 60; i++) f60.push_back(8'($urandom));
    for (int i = 0; i < 61; i++) f61.push_back(8'($urandom));
    for (int i = 0; i < 70; i++) f70.push_back(8'($urandom));

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mvalid0", {31'd0, m_valid0}, 0);
    chk("rst_mdata0", {24'd0, m_data0}, 0);
    chk("rst_mlast0", {31'd0, m_last0}, 0);
    chk("rst_sready0", {31'd0, s_ready0}, 0);
    chk("rst_done0", {31'd0, frame_done0}, 0);
    chk("rst_mvalid1", {31'd0, m_valid1}, 0);
    chk("rst_sready1", {31'd0, s_ready1}, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("rel_sready0", {31'd0, s_ready0}, 1);
    chk("rel_sready1", {31'd0, s_ready1}, 1);
    @(posedge clk); #1;

    // check-value frame, no padding
    push_known0();
    send(0, f9, 0);
    wait_drain(0);

    // short frame padded to 60
    push_frame(1, f9);
    send(1, f9, 0);
    wait_drain(1);

    // frames already at / above minimum length
    push_frame(1, f60);
    send(1, f60, 0);
    wait_drain(1);
    push_frame(1, f61);
    send(1, f61, 0);
    wait_drain(1);

    // output backpressure 1,0,0,1 with random input gaps
    mode = 1;
    push_frame(1, f70);
    send(1, f70, 3);
    wait_drain(1);
    mode = 0;
    repeat (2) begin @(posedge clk); #1; end

    // back-to-back frames must stream without an idle beat
    arm = 1;
    push_known0();
    push_known0();
    send(0, f9, 0);
    send(0, f9, 0);
    wait_drain(0);
    chk("b2b_span", last_cyc - first_cyc + 1, 26);

    // reset in the middle of padding discards the frame
    ign1 = 1;
    send(1, f9, 0);
    repeat (6) begin @(posedge clk); #1; end
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    ign1 = 0;
    @(negedge clk);
    chk("post_rst_mvalid1", {31'd0, m_valid1}, 0);
    chk("post_rst_mvalid0", {31'd0, m_valid0}, 0);
    chk("post_rst_sready1", {31'd0, s_ready1}, 1);
    repeat (5) begin @(posedge clk); #1; end
    push_known0();
    send(0, f9, 0);
    wait_drain(0);
    push_frame(1, f9);
    send(1, f9, 0);
    wait_drain(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
